// File: rtl/l15_req_rr_arbiter.sv
// -----------------------------------------------------------------------------
// l15_req_rr_arbiter
//
// Shares the single L1.5 request channel between the core-tile memory
// requesters. In port order these are: I$ miss, D$ miss-read, D$ write-buffer,
// D$ uncached read and D$ uncached write.
//
// Grants go round-robin and are limited by per-requester outstanding-
// transaction credits. A granted request is registered and held stable
// towards L1.5 until L1.5 acknowledges it.
//
// Ports
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   req_valid_i    per-requester request valid
//   req_ready_o    one-hot grant pulse; the payload is consumed in this cycle
//   req_payload_i  packed payloads; requester i at [i*PayloadWidth +: PayloadWidth]
//   l15_val_o      request valid towards L1.5
//   l15_payload_o  registered payload of the granted request
//   l15_portid_o   index of the granted requester
//   l15_ack_i      L1.5 accepted the current request
//   rtrn_valid_i   an L1.5 return completes one transaction
//   rtrn_portid_i  requester owning the return
//   credit_full_o  per-requester credit counter is at MaxOutstanding
//   err_o          sticky protocol-error flag
// -----------------------------------------------------------------------------
module l15_req_rr_arbiter #(
    parameter  int NumReq         = 5,
    parameter  int PayloadWidth   = 128,
    parameter  int MaxOutstanding = 2,
    localparam int IdWidth        = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NumReq-1:0]                req_valid_i,
    output logic [NumReq-1:0]                req_ready_o,
    input  logic [NumReq*PayloadWidth-1:0]   req_payload_i,
    output logic                             l15_val_o,
    output logic [PayloadWidth-1:0]          l15_payload_o,
    output logic [IdWidth-1:0]               l15_portid_o,
    input  logic                             l15_ack_i,
    input  logic                             rtrn_valid_i,
    input  logic [IdWidth-1:0]               rtrn_portid_i,
    output logic [NumReq-1:0]                credit_full_o,
    output logic                             err_o
);

    localparam int CntWidth = (MaxOutstanding > 0) ? $clog2(MaxOutstanding + 1) : 1;

    localparam logic [0:0]          ST_IDLE  = 1'b0;
    localparam logic [0:0]          ST_HOLD  = 1'b1;

    localparam logic [IdWidth-1:0]  ID_ZERO  = {IdWidth{1'b0}};
    localparam logic [IdWidth-1:0]  ID_ONE   = IdWidth'(1);
    localparam logic [IdWidth-1:0]  ID_LAST  = IdWidth'(NumReq - 1);

    localparam logic [CntWidth-1:0] CNT_ZERO = {CntWidth{1'b0}};
    localparam logic [CntWidth-1:0] CNT_ONE  = CntWidth'(1);
    localparam logic [CntWidth-1:0] CNT_MAX  = CntWidth'(MaxOutstanding);

    // Registered state
    logic [0:0]                        state_r;
    logic [IdWidth-1:0]                ptr_r;
    logic                              val_r;
    logic [PayloadWidth-1:0]           payload_r;
    logic [IdWidth-1:0]                portid_r;
    logic                              err_r;
    logic [NumReq-1:0][CntWidth-1:0]   cnt_r;
    logic [NumReq-1:0]                 full_r;

    // Combinational signals
    logic [NumReq-1:0]                 eligible_s;
    logic                              found_s;
    logic [IdWidth-1:0]                winner_s;
    logic                              grant_s;
    logic [NumReq-1:0]                 ready_s;
    logic [PayloadWidth-1:0]           sel_payload_s;
    logic                              rtrn_in_range_s;
    logic                              err_set_s;
    logic [NumReq-1:0][CntWidth-1:0]   cnt_nxt_s;
    logic [NumReq-1:0]                 full_nxt_s;

    // Eligibility and round-robin winner search starting at the pointer
    always_comb begin
        int idx_v;
        eligible_s = req_valid_i & ~full_r;
        found_s    = 1'b0;
        winner_s   = ID_ZERO;
        idx_v      = 0;
        for (int off = 0; off < NumReq; off++) begin
            idx_v = int'(ptr_r) + off;
            if (idx_v >= NumReq) begin
                idx_v = idx_v - NumReq;
            end else begin
                idx_v = idx_v;
            end
            if (!found_s && eligible_s[idx_v]) begin
                found_s  = 1'b1;
                winner_s = IdWidth'(idx_v);
            end else begin
                found_s  = found_s;
                winner_s = winner_s;
            end
        end
    end

    // Grant pulse; gated by rst_ni so nothing is consumed while held in reset
    always_comb begin
        grant_s       = (state_r == ST_IDLE) && found_s && rst_ni;
        sel_payload_s = req_payload_i[int'(winner_s)*PayloadWidth +: PayloadWidth];
        for (int i = 0; i < NumReq; i++) begin
            ready_s[i] = grant_s && (winner_s == IdWidth'(i));
        end
    end

    // Credit counter next-state and protocol error detection
    always_comb begin
        logic inc_v;
        logic dec_v;
        rtrn_in_range_s = rtrn_valid_i && (int'(rtrn_portid_i) < NumReq);
        err_set_s       = 1'b0;
        inc_v           = 1'b0;
        dec_v           = 1'b0;
        if (rtrn_valid_i && !rtrn_in_range_s) begin
            err_set_s = 1'b1;
        end else begin
            err_set_s = err_set_s;
        end
        if (l15_ack_i && (state_r != ST_HOLD)) begin
            err_set_s = 1'b1;
        end else begin
            err_set_s = err_set_s;
        end
        for (int i = 0; i < NumReq; i++) begin
            inc_v = grant_s && (winner_s == IdWidth'(i));
            dec_v = rtrn_in_range_s && (rtrn_portid_i == IdWidth'(i));
            if (inc_v && dec_v) begin
                cnt_nxt_s[i] = cnt_r[i];
            end else if (inc_v) begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
            end else if (dec_v) begin
                if (cnt_r[i] == CNT_ZERO) begin
                    // Return without an outstanding request: saturate and flag
                    cnt_nxt_s[i] = CNT_ZERO;
                    err_set_s    = 1'b1;
                end else begin
                    cnt_nxt_s[i] = cnt_r[i] - CNT_ONE;
                end
            end else begin
                cnt_nxt_s[i] = cnt_r[i];
            end
            full_nxt_s[i] = (cnt_nxt_s[i] == CNT_MAX);
        end
    end

    // Request-channel FSM: capture on grant, hold until ack, advance pointer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= ST_IDLE;
            ptr_r     <= ID_ZERO;
            val_r     <= 1'b0;
            payload_r <= {PayloadWidth{1'b0}};
            portid_r  <= ID_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_s) begin
                        state_r   <= ST_HOLD;
                        val_r     <= 1'b1;
                        payload_r <= sel_payload_s;
                        portid_r  <= winner_s;
                    end else begin
                        state_r   <= ST_IDLE;
                        val_r     <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (l15_ack_i) begin
                        state_r <= ST_IDLE;
                        val_r   <= 1'b0;
                        ptr_r   <= (portid_r == ID_LAST) ? ID_ZERO : (portid_r + ID_ONE);
                    end else begin
                        state_r <= ST_HOLD;
                        val_r   <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    val_r   <= 1'b0;
                end
            endcase
        end
    end

    // Credit counters, registered full flags and sticky error
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r  <= {NumReq{CNT_ZERO}};
            full_r <= {NumReq{1'b0}};
            err_r  <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            full_r <= full_nxt_s;
            err_r  <= err_r | err_set_s;
        end
    end

    assign req_ready_o   = ready_s;
    assign l15_val_o     = val_r;
    assign l15_payload_o = payload_r;
    assign l15_portid_o  = portid_r;
    assign credit_full_o = full_r;
    assign err_o         = err_r;

endmodule
